sd_card_arbiter: RTL

Shares the single SD-card sector controller between N independent sector clients (ROM/image loader, Disk II track buffer, ProDOS block device). It latches each client's read/write request and LBA, grants the controller to one client at a time in round-robin order, and routes busy, byte strobes, write data and completion back to the granted client only. Clients keep the same request/busy/done handshake they would use with a directly attached controller.

---
 rtl/sd_card_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sd_card_arbiter.sv
// Round-robin arbiter sharing one SD sector controller among N clients.
// Latches each client's request/LBA and routes the controller handshake to the owner only.
module sd_card_arbiter #(
  parameter int N       = 3,
  parameter int TIMEOUT = 1048576
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    ch_rd,
  input  logic [N-1:0]    ch_wr,
  input  logic [32*N-1:0] ch_lba,
  input  logic [8*N-1:0]  ch_wr_data,
  output logic [N-1:0]    ch_busy,
  output logic [N-1:0]    ch_rd_byte_strobe,
  output logic [N-1:0]    ch_done,
  output logic [N-1:0]    ch_err,
  output logic [N-1:0]    grant,
  output logic [31:0]     sd_lba,
  output logic            sd_rd,
  output logic            sd_wr,
  input  logic            sd_busy,
  input  logic            sd_done,
  input  logic            sd_rd_byte_strobe,
  output logic [7:0]      sd_wr_data
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, ACTIVE, RELEASE} state_e;

  state_e         state_q;
  logic [N-1:0]   pend_q, pend_d;
  logic [N-1:0]   op_q;
  logic [31:0]    lba_q [N];
  logic [IW-1:0]  rr_q, cur_q;
  logic [N-1:0]   grant_q, done_q, err_q;
  logic [31:0]    sd_lba_q;
  logic           sd_rd_q, sd_wr_q;
  logic [20:0]    cnt_q;

  logic [N-1:0]   new_req;
  logic [N-1:0]   sel_oh;
  logic [IW-1:0]  sel;
  logic           sel_vld;
  logic           fin_done, fin_timeout;

  // Round-robin pick: first pending client after the last one served.
  always_comb begin
    int idx;
    idx     = 0;
    sel     = rr_q;
    sel_vld = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(rr_q) + k) % N;
      if (!sel_vld && pend_q[idx]) begin
        sel_vld = 1'b1;
        sel     = IW'(idx);
      end
    end
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
  end

  // Pending set: new requests latch, the owner's entry clears when it finishes.
  always_comb begin
    new_req     = (ch_rd | ch_wr) & ~pend_q;
    fin_done    = ((state_q == ISSUE) || (state_q == ACTIVE)) && sd_done;
    fin_timeout = (state_q == ISSUE) && !sd_done && !sd_busy &&
                  (cnt_q == 21'(TIMEOUT - 1));
    if (fin_done || fin_timeout) begin
      pend_d = (pend_q | new_req) & ~grant_q;
    end else begin
      pend_d = pend_q | new_req;
    end
  end

  // Write data follows the registered grant; zero when nobody owns the controller.
  always_comb begin
    sd_wr_data = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        sd_wr_data = ch_wr_data[8*i +: 8];
      end
    end
  end

  assign ch_busy           = grant_q & {N{sd_busy}};
  assign ch_rd_byte_strobe = grant_q & {N{sd_rd_byte_strobe}};
  assign ch_done           = done_q;
  assign ch_err            = err_q;
  assign grant             = grant_q;
  assign sd_lba            = sd_lba_q;
  assign sd_rd             = sd_rd_q;
  assign sd_wr             = sd_wr_q;

  // Arbitration FSM with request latches and registered controller outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      op_q     <= '0;
      rr_q     <= IW'(N - 1);
      cur_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      sd_lba_q <= 32'h0;
      sd_rd_q  <= 1'b0;
      sd_wr_q  <= 1'b0;
      cnt_q    <= 21'd0;
      for (int i = 0; i < N; i++) begin
        lba_q[i] <= 32'h0;
      end
    end else begin
      pend_q <= pend_d;
      for (int i = 0; i < N; i++) begin
        if (new_req[i]) begin
          op_q[i]  <= ch_wr[i];
          lba_q[i] <= ch_lba[32*i +: 32];
        end
      end
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        IDLE: begin
          // A transfer left running across reset must drain before a new grant.
          if (!sd_busy && sel_vld) begin
            grant_q  <= sel_oh;
            cur_q    <= sel;
            sd_lba_q <= lba_q[sel];
            sd_rd_q  <= ~op_q[sel];
            sd_wr_q  <= op_q[sel];
            cnt_q    <= 21'd0;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (sd_done) begin
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            done_q  <= grant_q;
            rr_q    <= cur_q;
            state_q <= RELEASE;
          end else if (sd_busy) begin
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            state_q <= ACTIVE;
          end else if (fin_timeout) begin
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            err_q   <= grant_q;
            rr_q    <= cur_q;
            state_q <= RELEASE;
          end else begin
            cnt_q <= cnt_q + 21'd1;
          end
        end
        ACTIVE: begin
          if (sd_done) begin
            done_q  <= grant_q;
            rr_q    <= cur_q;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
